// File: rtl/io_fifo_port.sv
// io_fifo_port: memory-mapped I/O peripheral with a TX FIFO (bus -> device),
// an RX FIFO (device -> bus), STATUS/CTRL registers, DMA requests and a
// level interrupt. DATA at BASE_ADDR, STATUS at BASE_ADDR+1, CTRL at BASE_ADDR+2.
module io_fifo_port #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BASE_ADDR  = 1006,
  parameter int DEPTH      = 8,
  parameter int DREQ_LEVEL = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] address_Bus,
  inout  wire  [DATA_W-1:0] Data_Bus,
  input  logic              Read_DMA,
  input  logic              Read_CPU,
  input  logic              Write_DMA,
  input  logic              Write_CPU,
  output logic [DATA_W-1:0] dev_tx_data,
  output logic              dev_tx_valid,
  input  logic              dev_tx_ready,
  input  logic [DATA_W-1:0] dev_rx_data,
  input  logic              dev_rx_valid,
  output logic              dev_rx_ready,
  output logic              DREQ_TX,
  output logic              DREQ_RX,
  output logic              IRQ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(BASE_ADDR + 1);
  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(BASE_ADDR + 2);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LEVEL = CNT_W'(DREQ_LEVEL);

  // CTRL bit positions
  localparam int C_TX_EN   = 0;
  localparam int C_RX_EN   = 1;
  localparam int C_DREQ_TX = 2;
  localparam int C_DREQ_RX = 3;
  localparam int C_IRQ_EN  = 4;
  localparam int C_W1C     = 8;

  // Registered state
  logic [PTR_W-1:0]  tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PTR_W-1:0]  tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CNT_W-1:0]  tx_cnt_q,    tx_cnt_d;
  logic [PTR_W-1:0]  rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PTR_W-1:0]  rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CNT_W-1:0]  rx_cnt_q,    rx_cnt_d;
  logic [4:0]        ctrl_q,      ctrl_d;
  logic              ovf_q,       ovf_d;
  logic              unf_q,       unf_d;
  logic              conf_q,      conf_d;

  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [DATA_W-1:0] rx_mem_q [DEPTH];

  // Decode and handshake terms
  logic              rd, wr;
  logic              hit_data, hit_stat, hit_ctrl, hit;
  logic              bus_rd, bus_wr, conflict;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              ovf_set, unf_set, ctrl_wr, sticky_clr;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rd_data;

  assign rd       = Read_DMA | Read_CPU;
  assign wr       = Write_DMA | Write_CPU;
  assign hit_data = (address_Bus == ADDR_DATA);
  assign hit_stat = (address_Bus == ADDR_STAT);
  assign hit_ctrl = (address_Bus == ADDR_CTRL);
  assign hit      = hit_data | hit_stat | hit_ctrl;

  // A read always wins a same-cycle read/write collision; the write is dropped.
  assign bus_rd   = rd & hit;
  assign bus_wr   = wr & ~rd & hit;
  assign conflict = rd & wr & hit;

  assign tx_full  = (tx_cnt_q == CNT_FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CNT_FULL);
  assign rx_empty = (rx_cnt_q == '0);

  // Device-side handshakes; the registered count resets asynchronously, so
  // valid drops the moment RST rises.
  assign dev_tx_valid = ctrl_q[C_TX_EN] & ~tx_empty;
  assign dev_tx_data  = tx_mem_q[tx_rd_ptr_q];
  assign dev_rx_ready = ctrl_q[C_RX_EN] & ~rx_full & ~RST;

  assign tx_push    = bus_wr & hit_data & ~tx_full;
  assign ovf_set    = bus_wr & hit_data & tx_full;
  assign tx_pop     = dev_tx_valid & dev_tx_ready;
  assign rx_push    = dev_rx_valid & dev_rx_ready;
  assign rx_pop     = rd & hit_data & ~rx_empty;
  assign unf_set    = rd & hit_data & rx_empty;
  assign ctrl_wr    = bus_wr & hit_ctrl;
  assign sticky_clr = ctrl_wr & Data_Bus[C_W1C];

  assign DREQ_RX = ctrl_q[C_DREQ_RX] & (rx_cnt_q >= CNT_LEVEL);
  assign DREQ_TX = ctrl_q[C_DREQ_TX] & ((CNT_FULL - tx_cnt_q) >= CNT_LEVEL);
  assign IRQ     = ctrl_q[C_IRQ_EN] & (~rx_empty | ovf_q | unf_q | conf_q);

  // STATUS word assembly from registered state
  always_comb begin
    status_word                 = '0;
    status_word[0]              = tx_full;
    status_word[1]              = tx_empty;
    status_word[2]              = rx_full;
    status_word[3]              = rx_empty;
    status_word[4]              = ovf_q;
    status_word[5]              = unf_q;
    status_word[6]              = conf_q;
    status_word[8 +: CNT_W]     = tx_cnt_q;
    status_word[16 +: CNT_W]    = rx_cnt_q;
  end

  // Read-data mux; an empty RX FIFO reads as zero
  always_comb begin
    rd_data = '0;
    if (hit_data) begin
      if (!rx_empty) rd_data = rx_mem_q[rx_rd_ptr_q];
    end else if (hit_stat) begin
      rd_data = status_word;
    end else if (hit_ctrl) begin
      rd_data[4:0] = ctrl_q;
    end
  end

  assign Data_Bus = (bus_rd & ~RST) ? rd_data : {DATA_W{1'bz}};

  // Next-state for pointers, counts, CTRL and sticky flags
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    ctrl_d      = ctrl_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    conf_d      = conf_q;

    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    if (ctrl_wr) ctrl_d = Data_Bus[4:0];

    // Clear first so a coincident set survives the same edge.
    if (sticky_clr) begin
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      conf_d = 1'b0;
    end
    if (ovf_set)  ovf_d  = 1'b1;
    if (unf_set)  unf_d  = 1'b1;
    if (conflict) conf_d = 1'b1;
  end

  // Control state register with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      ctrl_q      <= 5'b00011;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      conf_q      <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      conf_q      <= conf_d;
    end
  end

  // FIFO storage write ports; contents are not reset
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= Data_Bus;
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= dev_rx_data;
  end

endmodule

// File: tb/tb_io_fifo_port.sv
// Testbench for io_fifo_port: queue-based reference model, scoreboarded
// bus reads, device TX transfers and per-cycle status outputs.
`timescale 1ns/1ps
module tb_io_fifo_port;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BASE = 1006;
  localparam int DEPTH = 8;
  localparam int LVL = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] address_Bus = '0;
  wire  [DW-1:0] Data_Bus;
  logic [DW-1:0] bus_drv = '0;
  logic          bus_oe = 1'b0;
  logic          Read_DMA = 0, Read_CPU = 0, Write_DMA = 0, Write_CPU = 0;
  logic [DW-1:0] dev_tx_data;
  logic          dev_tx_valid;
  logic          dev_tx_ready = 0;
  logic [DW-1:0] dev_rx_data = '0;
  logic          dev_rx_valid = 0;
  logic          dev_rx_ready;
  logic          DREQ_TX, DREQ_RX, IRQ;

  assign Data_Bus = bus_oe ? bus_drv : {DW{1'bz}};

  io_fifo_port #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH), .DREQ_LEVEL(LVL)) dut (
    .CLK(CLK), .RST(RST), .address_Bus(address_Bus), .Data_Bus(Data_Bus),
    .Read_DMA(Read_DMA), .Read_CPU(Read_CPU), .Write_DMA(Write_DMA), .Write_CPU(Write_CPU),
    .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready),
    .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready),
    .DREQ_TX(DREQ_TX), .DREQ_RX(DREQ_RX), .IRQ(IRQ));

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  logic [4:0]    m_ctrl = 5'h3;
  logic          m_ovf = 0, m_unf = 0, m_conf = 0;

  typedef struct packed { logic txv; logic rxr; logic dtx; logic drx; logic irq; } flags_t;

  // Scoreboard queues
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] txd_q[$];
  flags_t        fl_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_status();
    logic [DW-1:0] s;
    s = '0;
    s[0] = (m_tx.size() == DEPTH);
    s[1] = (m_tx.size() == 0);
    s[2] = (m_rx.size() == DEPTH);
    s[3] = (m_rx.size() == 0);
    s[4] = m_ovf;
    s[5] = m_unf;
    s[6] = m_conf;
    s[15:8]  = 8'(m_tx.size());
    s[23:16] = 8'(m_rx.size());
    return s;
  endfunction

  function automatic logic [DW-1:0] m_read(input int off);
    logic [DW-1:0] v;
    v = '0;
    if (off == 0) v = (m_rx.size() > 0) ? m_rx[0] : '0;
    else if (off == 1) v = m_status();
    else v[4:0] = m_ctrl;
    return v;
  endfunction

  function automatic flags_t m_flags();
    flags_t f;
    f.txv = m_ctrl[0] && (m_tx.size() > 0);
    f.rxr = m_ctrl[1] && (m_rx.size() < DEPTH);
    f.dtx = m_ctrl[2] && ((DEPTH - m_tx.size()) >= LVL);
    f.drx = m_ctrl[3] && (m_rx.size() >= LVL);
    f.irq = m_ctrl[4] && ((m_rx.size() > 0) || m_ovf || m_unf || m_conf);
    return f;
  endfunction

  // One bus/device cycle: drive, record expectations, clock, advance model.
  task automatic cycle(input logic rc, input logic rdm, input logic wc, input logic wd,
                       input int off, input logic [31:0] wdata,
                       input logic txr, input logic rxv, input logic [31:0] rxd);
    logic rd, wr, hit, bw, tx_pop, rx_push, rx_pop, tx_push, clr;
    rd  = rc | rdm;
    wr  = wc | wd;
    hit = (off >= 0) && (off <= 2);
    Read_CPU = rc; Read_DMA = rdm; Write_CPU = wc; Write_DMA = wd;
    address_Bus = AW'(BASE + off);
    bus_drv = wdata;
    bus_oe  = wr && !(rd && hit);
    dev_tx_ready = txr;
    dev_rx_valid = rxv;
    dev_rx_data  = rxd;

    fl_q.push_back(m_flags());
    if (rd && hit) rd_q.push_back(m_read(off));
    tx_pop  = m_ctrl[0] && (m_tx.size() > 0) && txr;
    if (tx_pop) txd_q.push_back(m_tx[0]);
    rx_push = m_ctrl[1] && (m_rx.size() < DEPTH) && rxv;
    rx_pop  = rd && hit && (off == 0) && (m_rx.size() > 0);
    bw      = wr && !rd && hit;
    tx_push = bw && (off == 0) && (m_tx.size() < DEPTH);
    clr     = bw && (off == 2) && wdata[8];

    @(posedge CLK);
    if (clr) begin m_ovf = 0; m_unf = 0; m_conf = 0; end
    if (rd && hit && off == 0 && m_rx.size() == 0) m_unf = 1;
    if (bw && off == 0 && m_tx.size() == DEPTH) m_ovf = 1;
    if (rd && wr && hit) m_conf = 1;
    if (bw && off == 2) m_ctrl = wdata[4:0];
    if (tx_pop)  void'(m_tx.pop_front());
    if (tx_push) m_tx.push_back(wdata);
    if (rx_pop)  void'(m_rx.pop_front());
    if (rx_push) m_rx.push_back(rxd);
    #1;
  endtask

  task automatic bwr(input int off, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, off, '0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, off, d, 1'b0, 1'b0, '0);
  endtask

  task automatic wr_only(input int off, input logic [31:0] d, input logic txr);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, off, d, txr, 1'b0, '0);
  endtask

  task automatic rd_cpu(input int off);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, off, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd_dma(input int off);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, off, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, '0, txr, 1'b0, '0);
  endtask

  task automatic dev_push(input logic [31:0] d);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, '0, 1'b0, 1'b1, d);
  endtask

  // Assert reset from mid-cycle, check outputs immediately, then release.
  task automatic do_reset();
    Read_CPU = 0; Read_DMA = 0; Write_CPU = 0; Write_DMA = 0; bus_oe = 0;
    dev_rx_valid = 0;
    RST = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(dev_tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(dev_rx_ready), 32'd0);
    chk("rst_irq_dreq", {29'd0, IRQ, DREQ_TX, DREQ_RX}, 32'd0);
    m_tx.delete(); m_rx.delete();
    m_ctrl = 5'h3; m_ovf = 0; m_unf = 0; m_conf = 0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents this cycle against the queues.
  always @(negedge CLK) begin
    if (!RST) begin
      if (fl_q.size() > 0) begin
        flags_t f;
        f = fl_q.pop_front();
        chk("dev_tx_valid", 32'(dev_tx_valid), 32'(f.txv));
        chk("dev_rx_ready", 32'(dev_rx_ready), 32'(f.rxr));
        chk("DREQ_TX", 32'(DREQ_TX), 32'(f.dtx));
        chk("DREQ_RX", 32'(DREQ_RX), 32'(f.drx));
        chk("IRQ", 32'(IRQ), 32'(f.irq));
      end
      if ((Read_CPU || Read_DMA) && address_Bus >= AW'(BASE) && address_Bus <= AW'(BASE + 2)) begin
        if (rd_q.size() == 0) chk("read_unexpected", Data_Bus, 32'hFFFF_FFFF);
        else chk("read_data", Data_Bus, rd_q.pop_front());
      end
      if (dev_tx_valid && dev_tx_ready) begin
        if (txd_q.size() == 0) chk("tx_unexpected", dev_tx_data, 32'hFFFF_FFFF);
        else chk("dev_tx_data", dev_tx_data, txd_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and register readback
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_hold_rx_ready", 32'(dev_rx_ready), 32'd0);
    chk("rst_hold_tx_valid", 32'(dev_tx_valid), 32'd0);
    RST = 1'b0;
    rd_cpu(1);
    rd_cpu(2);
    rd_cpu(-1);
    rd_cpu(3);

    // TX fill with device stalled, overflow, then drain in order
    for (int i = 0; i < 8; i++) wr_only(0, 32'h11 + i, 1'b0);
    rd_cpu(1);
    wr_only(0, 32'h99, 1'b0);
    rd_cpu(1);
    idle(8, 1'b1);
    rd_cpu(1);

    // RX path with DMA request enabled, then underflow
    wr_only(2, 32'h10B, 1'b0);
    for (int i = 0; i < 4; i++) dev_push(32'hA0 + i);
    idle(1, 1'b0);
    for (int i = 0; i < 5; i++) rd_dma(0);
    idle(2, 1'b0);
    rd_cpu(1);

    // Concurrent device push and bus pop across pointer wrap
    wr_only(2, 32'h10B, 1'b0);
    for (int i = 0; i < 3; i++) dev_push(32'hC0 + i);
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 32'hD00 + i);
    rd_cpu(1);
    while (m_rx.size() > 0) rd_dma(0);

    // Read/write conflict and W1C clear
    wr_only(2, 32'h13, 1'b0);
    wr_only(0, 32'h5A, 1'b0);
    dev_push(32'h55);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h77, 1'b0, 1'b0, '0);
    rd_cpu(1);
    wr_only(2, 32'h110, 1'b0);
    idle(2, 1'b0);
    rd_cpu(1);
    wr_only(2, 32'h3, 1'b0);
    idle(2, 1'b1);

    // Reset in the middle of a TX burst
    for (int i = 0; i < 5; i++) wr_only(0, 32'hE0 + i, 1'b0);
    idle(1, 1'b0);
    do_reset();
    rd_cpu(1);
    rd_cpu(2);

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      int off;
      logic rc, rdm, wc, wd;
      logic [31:0] d;
      off = int'($urandom_range(0, 4)) - 1;
      rc  = ($urandom_range(0, 3) == 0);
      rdm = ($urandom_range(0, 3) == 0);
      wc  = ($urandom_range(0, 2) == 0);
      wd  = ($urandom_range(0, 5) == 0);
      d   = $urandom;
      if (off == 2 && $urandom_range(0, 3) != 0) d = (d & 32'h11C) | 32'h3;
      cycle(rc, rdm, wc, wd, off, d, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom);
    end
    idle(2, 1'b0);

    @(negedge CLK);
    #1;
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("txd_q_drained", 32'(txd_q.size()), 32'd0);
    chk("fl_q_drained", 32'(fl_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_fifo_port.md
# io_fifo_port

Parametrised memory-mapped I/O peripheral on the shared CPU/DMA bus, successor to the single-register I/O port. It replaces one fixed data register with a TX FIFO (bus → device) and an RX FIFO (device → bus), adds STATUS and CTRL registers at a configurable base address, and raises DMA requests and an interrupt based on FIFO levels. It connects to the same `address_Bus`/`Data_Bus` and the same four read/write strobes as the other I/O devices.

## Interface
- `DATA_W`, 32: bus data width. Must be ≥ 24.
- `ADDR_W`, 32: address bus width.
- `BASE_ADDR`, 1006: address of the DATA register. STATUS is at `BASE_ADDR+1`; CTRL is at `BASE_ADDR+2`.
- `DEPTH`, 8: entries per FIFO. Must be a power of 2, from 2 to 128.
- `DREQ_LEVEL`, 4: DMA request threshold, 1..`DEPTH`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `address_Bus` in `ADDR_W`: bus address.
- `Data_Bus` inout `DATA_W`: shared tri-state data bus.
- `Read_DMA`, `Read_CPU` in 1: read strobes; treated as one OR-ed read.
- `Write_DMA`, `Write_CPU` in 1: write strobes; treated as one OR-ed write.
- `dev_tx_data` out `DATA_W`: TX FIFO head.
- `dev_tx_valid` out 1 / `dev_tx_ready` in 1: TX valid/ready handshake.
- `dev_rx_data` in `DATA_W`: RX FIFO input data.
- `dev_rx_valid` in 1 / `dev_rx_ready` out 1: RX valid/ready handshake.
- `DREQ_TX`, `DREQ_RX` out 1: DMA requests.
- `IRQ` out 1: level interrupt.

## Operation
- **Address hit.** A hit is `address_Bus` in [`BASE_ADDR`, `BASE_ADDR+2`]. `Data_Bus` is driven only on a hit with a read strobe and `RST` low; otherwise it is Z.
- **DATA register.**
  - Write pushes `Data_Bus` into the TX FIFO. If the FIFO is full, the write is dropped and sticky OVF is set.
  - Read drives the RX FIFO head combinationally and pops at the closing edge. If the FIFO is empty, the read drives 0 and sets sticky UNF.
- **STATUS register (read-only; writes ignored).**
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
  - bit4 OVF, bit5 UNF, bit6 CONFLICT.
  - [15:8] tx_count, [23:16] rx_count, other bits 0.
- **CTRL register (R/W, reset value 0x3).**
  - bit0 tx_en, bit1 rx_en, bit2 dreq_tx_en, bit3 dreq_rx_en, bit4 irq_en.
  - bit8 is write-1-to-clear for all sticky bits. It is not stored and always reads 0.
- **Read and write in the same cycle.** Any read strobe together with any write strobe on a hit: the read completes, the write is dropped, and CONFLICT is set.
- **Device TX side.**
  - `dev_tx_valid` = tx_en & !tx_empty; `dev_tx_data` = TX FIFO head.
  - A pop occurs on an edge where valid & ready are both high.
- **Device RX side.**
  - `dev_rx_ready` = rx_en & !rx_full & !RST.
  - A push occurs on an edge where valid & ready are both high.
- **Simultaneous push and pop on one FIFO.** Both happen and the count is unchanged.
- **Full/empty evaluation.** Full and empty are evaluated on pre-edge state. A push to a full FIFO is rejected even if a pop occurs in the same cycle.
- **Pointers and counters.** Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Counts are `$clog2(DEPTH)+1` bits and range 0..`DEPTH`.
- **Request and interrupt outputs.**
  - `DREQ_RX` = dreq_rx_en & (rx_count ≥ `DREQ_LEVEL`).
  - `DREQ_TX` = dreq_tx_en & (`DEPTH` − tx_count ≥ `DREQ_LEVEL`).
  - `IRQ` = irq_en & (!rx_empty | OVF | UNF | CONFLICT).
- **Disabled FIFOs.** Clearing tx_en or rx_en stalls only the device side. Bus access to the FIFO contents is unaffected.

## Timing
- **Reset values (while `RST` high and immediately after release).**
  - Pointers and counts 0; sticky bits 0; CTRL 0x3.
  - `dev_tx_valid` 0, `DREQ_TX` 0, `DREQ_RX` 0, `IRQ` 0, `Data_Bus` Z.
  - `dev_rx_ready` 0 while `RST` is high, 1 after release.
- **Reset mid-operation.** In-flight transfers are discarded and FIFO contents are considered lost. No push or pop completes on the edge where `RST` is high.
- **Read data.** Valid combinationally in the same cycle as the strobe, zero wait states.
- **State updates.** Pop, push, register write and sticky set all take effect at the rising edge that ends the strobe cycle.
- **Derived outputs.** STATUS, DREQ, IRQ and device-side valid/ready reflect the new state one cycle after the causing edge. All are combinational from registered state.
- **Strobe interpretation.** A strobe held for N cycles is N accesses: each cycle pushes or pops once.
- **Sticky-bit priority.** A sticky set and a W1C clear on the same edge: the set wins.
- **Latency.**
  - Bus write to `dev_tx_valid`: 1 cycle.
  - Device RX push to readable at DATA: 1 cycle.

## Test plan
- **Reset and register readback.** Reset, then read `BASE_ADDR+1` → 0x0000000A; read `BASE_ADDR+2` → 0x3; `dev_rx_ready`=1, `dev_tx_valid`=0, `Data_Bus` Z on a non-hit address (1005).
- **TX FIFO fill and drain.** With `dev_tx_ready`=0, write 0x11..0x18 via CPU → STATUS tx_full=1, tx_count=8. A 9th write is dropped and sets OVF. Then raise ready → `dev_tx_data` 0x11..0x18 in order over 8 cycles, then tx_empty=1.
- **RX FIFO to bus.** Push 0xA0..0xA3 from the device side → `DREQ_RX`=1 after the 4th push (with CTRL=0xB). DMA reads return 0xA0..0xA3. A 5th read returns 0 and sets UNF; `DREQ_RX` falls 1 cycle after rx_count<4.
- **Pointer wrap-around under load.** Concurrent device push and bus pop for 20 cycles at depth 8 → pointers wrap, rx_count constant, data order preserved, no OVF/UNF.
- **Read/write conflict.** `Read_CPU` and `Write_DMA` both high at `BASE_ADDR` → the read returns the RX head, the TX FIFO is unchanged, CONFLICT=1, and `IRQ`=1 (irq_en set). Write CTRL 0x110 → sticky bits clear and `IRQ` falls 1 cycle later (RX empty).
- **Reset mid-transfer.** Assert `RST` mid-burst with 5 entries in the TX FIFO → `dev_tx_valid` drops immediately, and tx_count reads 0 after release.
